status_flag_unit: RTL and testbench
===================================

Name: status_flag_unit

Overview:
- Parametrised successor to the ALU status-detector/condition-mux pair.
- Detects Z, C, V and S from an ALU result of WIDTH bits and holds them in a 4-bit flag register with per-flag write mask.
- Evaluates a 4-bit condition code, including signed and unsigned compares, into Dcondn for the branch logic.
- Adds a DEPTH-entry flag save/restore stack for interrupt/call context, with full/empty status and a sticky error flag.

Parameters:
- WIDTH, 16, ALU result width in bits; minimum 2.
- DEPTH, 4, flag-stack entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), localparam; stack pointer width.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-low reset.
- z  in  WIDTH  ALU result.
- c_n  in  1  Carry out of the MSB.
- c_n_minus_1  in  1  Carry into the MSB.
- Lflag  in  1  Load detected flags this cycle.
- flag_mask  in  4  Per-flag load enable {S,V,C,Z}; applies to Lflag only.
- wr_flags  in  1  Direct flag write.
- wr_data  in  4  Flag value for wr_flags, ordered {S,V,C,Z}.
- push  in  1  Save the current flags on the stack.
- pop  in  1  Restore the flags from the top of the stack.
- err_clr  in  1  Clear stack_err.
- IR12_9  in  4  Condition select.
- Dcondn  out  1  Condition result.
- flags  out  4  Registered {S,V,C,Z}.
- stack_full  out  1  Count equals DEPTH.
- stack_empty  out  1  Count equals 0.
- stack_err  out  1  Sticky overflow/underflow flag.
- stack_cnt  out  PTR_W+1  Number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - flags=4'b0000, stack_cnt=0, stack_empty=1, stack_full=0, stack_err=0.
  - Stack contents are don't-care.
- Detection (combinational):
  - Zin = NOR of all z bits.
  - Cin = c_n.
  - Vin = c_n XOR c_n_minus_1.
  - Sin = z[WIDTH-1].
- Flag register update at posedge clk, priority highest first:
  - Valid pop: flags <= top entry.
  - Else wr_flags: flags <= wr_data.
  - Else Lflag: each bit whose flag_mask bit is 1 loads its detected value; the others hold.
  - Else hold.
- Push:
  - Stores the pre-edge flags value, so the value saved is the one before any same-cycle update.
  - The flag-update rules above still apply in the same cycle.
  - Valid only when not full; stack_cnt+1.
- Pop:
  - Valid only when not empty; stack_cnt-1.
- push and pop together:
  - Stack and count unchanged; no error raised.
  - The pop does not restore; flags follow wr_flags/Lflag.
- Invalid operations:
  - Push when full: ignored, stack_err <= 1.
  - Pop when empty: ignored, stack_err <= 1; flags then follow wr_flags/Lflag.
- stack_err is sticky until err_clr.
  - If err_clr coincides with a new error, the error wins and stack_err stays 1.
- Stack is LIFO, indexed by stack_cnt; there is no wrap-around.
- Dcondn:
  - Combinational from the registered flags and IR12_9; zero latency from IR12_9.
  - Reflects an Lflag load one cycle after it.
  - Encoding:
    - 0: 1 (always)
    - 1: Z
    - 2: !Z
    - 3: C
    - 4: !C
    - 5: V
    - 6: !V
    - 7: S
    - 8: !S
    - 9: S==V (signed GE)
    - 10: S!=V (signed LT)
    - 11: !Z & S==V (signed GT)
    - 12: Z | S!=V (signed LE)
    - 13: C & !Z (unsigned HI)
    - 14: !C | Z (unsigned LS)
    - 15: 0 (never)
  - Codes 0-8 match the existing muxDcondn mapping.
- stack_full, stack_empty and stack_cnt are registered-count derived with no glitch paths. stack_full/stack_empty are pure decodes of stack_cnt.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_ALWAYS..COND_NEVER.
  - Flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2, FLG_S=3.
  - A 4-bit flags_t typedef.
- One natural sub-module: flag_cond_eval, the combinational flags + IR12_9 -> Dcondn decoder. It is reusable by the branch unit.
- Detection, flag register and stack stay in the top module.

Test Plan:
- Reset then IR12_9=1/2/0/15 -> flags=0, Dcondn=0/1/1/0, stack_empty=1.
- WIDTH=16: z=16'h0000, c_n=1, c_n_minus_1=0, Lflag=1, mask=4'hF -> next cycle flags={S0,V1,C1,Z1}; IR12_9=13 -> 0, IR12_9=14 -> 1, IR12_9=10 -> 1.
- mask=4'b0001 with z=16'h8000, c_n=1 over flags=0 -> only Z updates (stays 0); S/C unchanged at 0.
- Load flags 4'hA, push; wr_flags 4'h5, push with wr_data 4'h3 -> stack holds A,5 and flags=3; pop -> 5; pop -> A; stack_empty=1.
- Five pushes with DEPTH=4 -> stack_full after the 4th, 5th ignored, stack_err=1, cnt=4. err_clr together with pop -> stack_err=0 and cnt=3.
- pop on empty together with Lflag -> flags load detected values, stack_err=1. push+pop together at cnt=2 -> cnt stays 2, no error. Assert rst low mid-sequence -> all outputs at reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared flag layout, condition-code encodings and flag type for the status
// flag unit and any branch logic that decodes the same condition codes.
package status_flag_unit_pkg;

   typedef logic [3:0] flags_t;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_V = 2;
   localparam int FLG_S = 3;

   localparam logic [3:0] COND_ALWAYS = 4'd0;
   localparam logic [3:0] COND_Z      = 4'd1;
   localparam logic [3:0] COND_NZ     = 4'd2;
   localparam logic [3:0] COND_C      = 4'd3;
   localparam logic [3:0] COND_NC     = 4'd4;
   localparam logic [3:0] COND_V      = 4'd5;
   localparam logic [3:0] COND_NV     = 4'd6;
   localparam logic [3:0] COND_S      = 4'd7;
   localparam logic [3:0] COND_NS     = 4'd8;
   localparam logic [3:0] COND_GE     = 4'd9;
   localparam logic [3:0] COND_LT     = 4'd10;
   localparam logic [3:0] COND_GT     = 4'd11;
   localparam logic [3:0] COND_LE     = 4'd12;
   localparam logic [3:0] COND_HI     = 4'd13;
   localparam logic [3:0] COND_LS     = 4'd14;
   localparam logic [3:0] COND_NEVER  = 4'd15;

endpackage

// File: rtl/status_flag_unit_flag_cond_eval.sv
// Combinational condition decoder: registered {S,V,C,Z} plus a 4-bit condition
// select produce the branch-taken bit. Shared with the branch unit.
module flag_cond_eval
   import status_flag_unit_pkg::*;
(
   input  flags_t     flags,
   input  logic [3:0] cond,
   output logic       taken
);

   logic f_z, f_c, f_v, f_s;

   assign f_z = flags[FLG_Z];
   assign f_c = flags[FLG_C];
   assign f_v = flags[FLG_V];
   assign f_s = flags[FLG_S];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_ALWAYS: taken = 1'b1;
         COND_Z:      taken = f_z;
         COND_NZ:     taken = ~f_z;
         COND_C:      taken = f_c;
         COND_NC:     taken = ~f_c;
         COND_V:      taken = f_v;
         COND_NV:     taken = ~f_v;
         COND_S:      taken = f_s;
         COND_NS:     taken = ~f_s;
         COND_GE:     taken = (f_s == f_v);
         COND_LT:     taken = (f_s != f_v);
         COND_GT:     taken = ~f_z & (f_s == f_v);
         COND_LE:     taken = f_z | (f_s != f_v);
         COND_HI:     taken = f_c & ~f_z;
         COND_LS:     taken = ~f_c | f_z;
         COND_NEVER:  taken = 1'b0;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/status_flag_unit.sv
// ALU status detection, masked flag register, LIFO flag save/restore stack
// with sticky overflow/underflow error, and condition evaluation into Dcondn.
module status_flag_unit
   import status_flag_unit_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] z,
   input  logic             c_n,
   input  logic             c_n_minus_1,
   input  logic             Lflag,
   input  logic [3:0]       flag_mask,
   input  logic             wr_flags,
   input  logic [3:0]       wr_data,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   input  logic [3:0]       IR12_9,
   output logic             Dcondn,
   output logic [3:0]       flags,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err,
   output logic [PTR_W:0]   stack_cnt
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   flags_t           flags_r;
   flags_t           det_flags;
   flags_t           stack_mem [DEPTH];
   logic [PTR_W:0]   cnt_r;
   logic [PTR_W-1:0] top_idx;
   logic             err_r;
   logic             is_full, is_empty;
   logic             push_only, pop_only;
   logic             push_ok, pop_ok, op_err;

   always_comb begin
      det_flags        = '0;
      det_flags[FLG_Z] = ~|z;
      det_flags[FLG_C] = c_n;
      det_flags[FLG_V] = c_n ^ c_n_minus_1;
      det_flags[FLG_S] = z[WIDTH-1];
   end

   assign is_full  = (cnt_r == FULL_CNT);
   assign is_empty = (cnt_r == '0);

   // Simultaneous push and pop cancel: no stack movement, no restore, no error.
   assign push_only = push & ~pop;
   assign pop_only  = pop & ~push;
   assign push_ok   = push_only & ~is_full;
   assign pop_ok    = pop_only & ~is_empty;
   assign op_err    = (push_only & is_full) | (pop_only & is_empty);

   // Low pointer bits wrap correctly for cnt_r == DEPTH; only used when not empty.
   assign top_idx = cnt_r[PTR_W-1:0] - PTR_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_r <= '0;
      end else if (pop_ok) begin
         flags_r <= stack_mem[top_idx];
      end else if (wr_flags) begin
         flags_r <= wr_data;
      end else if (Lflag) begin
         flags_r <= (flags_r & ~flag_mask) | (det_flags & flag_mask);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (push_ok) begin
         cnt_r <= cnt_r + 1'b1;
      end else if (pop_ok) begin
         cnt_r <= cnt_r - 1'b1;
      end
   end

   // A new error outranks a coincident clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_r <= 1'b0;
      end else if (op_err) begin
         err_r <= 1'b1;
      end else if (err_clr) begin
         err_r <= 1'b0;
      end
   end

   // Stack contents carry no reset; the count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         stack_mem[cnt_r[PTR_W-1:0]] <= flags_r;
      end
   end

   flag_cond_eval u_cond (
      .flags (flags_r),
      .cond  (IR12_9),
      .taken (Dcondn)
   );

   assign flags       = flags_r;
   assign stack_cnt   = cnt_r;
   assign stack_full  = is_full;
   assign stack_empty = is_empty;
   assign stack_err   = err_r;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: detection, masked load, condition codes,
// flag stack push/pop/overflow/underflow, sticky error and asynchronous reset.
module tb_status_flag_unit;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] z;
   logic             c_n;
   logic             c_n_minus_1;
   logic             Lflag;
   logic [3:0]       flag_mask;
   logic             wr_flags;
   logic [3:0]       wr_data;
   logic             push;
   logic             pop;
   logic             err_clr;
   logic [3:0]       IR12_9;
   logic             Dcondn;
   logic [3:0]       flags;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_err;
   logic [PTR_W:0]   stack_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   status_flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .z           (z),
      .c_n         (c_n),
      .c_n_minus_1 (c_n_minus_1),
      .Lflag       (Lflag),
      .flag_mask   (flag_mask),
      .wr_flags    (wr_flags),
      .wr_data     (wr_data),
      .push        (push),
      .pop         (pop),
      .err_clr     (err_clr),
      .IR12_9      (IR12_9),
      .Dcondn      (Dcondn),
      .flags       (flags),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err),
      .stack_cnt   (stack_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      Lflag = 1'b0; flag_mask = 4'h0; wr_flags = 1'b0; wr_data = 4'h0;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   // One clock edge, then release the one-shot controls and sample 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic cond_check(input string tag, input logic [3:0] code, input logic exp);
      IR12_9 = code;
      #1;
      check(tag, {7'd0, Dcondn}, {7'd0, exp});
   endtask

   task automatic stack_check(input string tag, input logic [3:0] exp_flags,
                              input int exp_cnt, input logic exp_err);
      check({tag, "_flags"}, {4'd0, flags}, {4'd0, exp_flags});
      check({tag, "_cnt"}, 8'(stack_cnt), 8'(exp_cnt));
      check({tag, "_err"}, {7'd0, stack_err}, {7'd0, exp_err});
      check({tag, "_full"}, {7'd0, stack_full}, {7'd0, (exp_cnt == DEPTH)});
      check({tag, "_empty"}, {7'd0, stack_empty}, {7'd0, (exp_cnt == 0)});
   endtask

   initial begin
      rst = 1'b0;
      z = '0; c_n = 1'b0; c_n_minus_1 = 1'b0; IR12_9 = 4'd0;
      idle_inputs();
      #12;
      stack_check("reset", 4'h0, 0, 1'b0);
      rst = 1'b1;
      cond_check("rst_cond_z", 4'd1, 1'b0);
      cond_check("rst_cond_nz", 4'd2, 1'b1);
      cond_check("rst_cond_always", 4'd0, 1'b1);
      cond_check("rst_cond_never", 4'd15, 1'b0);

      // Full-mask detect: z=0, carry out with no carry-in -> S0 V1 C1 Z1
      @(posedge clk); #1;
      z = 16'h0000; c_n = 1'b1; c_n_minus_1 = 1'b0; Lflag = 1'b1; flag_mask = 4'hF;
      tick();
      check("detect_all", {4'd0, flags}, 8'h07);
      cond_check("cond_hi", 4'd13, 1'b0);
      cond_check("cond_ls", 4'd14, 1'b1);
      cond_check("cond_lt", 4'd10, 1'b1);
      cond_check("cond_ge", 4'd9, 1'b0);
      cond_check("cond_gt", 4'd11, 1'b0);
      cond_check("cond_le", 4'd12, 1'b1);
      cond_check("cond_v", 4'd5, 1'b1);
      cond_check("cond_ns", 4'd8, 1'b1);

      // Masked loads over flags=0
      wr_flags = 1'b1; wr_data = 4'h0;
      tick();
      check("wr_zero", {4'd0, flags}, 8'h00);
      z = 16'h8000; c_n = 1'b1; c_n_minus_1 = 1'b0; Lflag = 1'b1; flag_mask = 4'b0001;
      tick();
      check("mask_z_only", {4'd0, flags}, 8'h00);
      Lflag = 1'b1; flag_mask = 4'b1000;
      tick();
      check("mask_s_only", {4'd0, flags}, 8'h08);
      cond_check("cond_s", 4'd7, 1'b1);
      cond_check("cond_c", 4'd3, 1'b0);
      // wr_flags outranks Lflag
      wr_flags = 1'b1; wr_data = 4'h2; Lflag = 1'b1; flag_mask = 4'hF;
      tick();
      check("wr_over_load", {4'd0, flags}, 8'h02);

      // Push saves pre-edge flags
      wr_flags = 1'b1; wr_data = 4'hA;
      tick();
      push = 1'b1;
      tick();
      stack_check("push_a", 4'hA, 1, 1'b0);
      wr_flags = 1'b1; wr_data = 4'h5;
      tick();
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h3;
      tick();
      stack_check("push_5_wr3", 4'h3, 2, 1'b0);
      pop = 1'b1;
      tick();
      stack_check("pop_5", 4'h5, 1, 1'b0);
      pop = 1'b1; wr_flags = 1'b1; wr_data = 4'hF;
      tick();
      stack_check("pop_a", 4'hA, 0, 1'b0);

      // Fill, overflow, then clear alongside a pop
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h1; tick();
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h2; tick();
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h3; tick();
      stack_check("fill3", 4'h3, 3, 1'b0);
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h4; tick();
      stack_check("fill4", 4'h4, 4, 1'b0);
      push = 1'b1; wr_flags = 1'b1; wr_data = 4'h6; tick();
      stack_check("overflow", 4'h6, 4, 1'b1);
      err_clr = 1'b1; pop = 1'b1; tick();
      stack_check("clr_pop", 4'h3, 3, 1'b0);
      pop = 1'b1; tick();
      stack_check("pop_2", 4'h2, 2, 1'b0);
      pop = 1'b1; tick();
      stack_check("pop_1", 4'h1, 1, 1'b0);
      pop = 1'b1; tick();
      stack_check("pop_a2", 4'hA, 0, 1'b0);

      // Underflow with Lflag: z=8001, c_n=0, c_n-1=1 -> S1 V1 C0 Z0
      z = 16'h8001; c_n = 1'b0; c_n_minus_1 = 1'b1;
      pop = 1'b1; Lflag = 1'b1; flag_mask = 4'hF;
      tick();
      stack_check("underflow_load", 4'hC, 0, 1'b1);
      err_clr = 1'b1; pop = 1'b1;
      tick();
      stack_check("err_beats_clr", 4'hC, 0, 1'b1);
      err_clr = 1'b1;
      tick();
      stack_check("err_clr", 4'hC, 0, 1'b0);

      // push+pop together at cnt=2
      push = 1'b1; tick();
      wr_flags = 1'b1; wr_data = 4'h9; tick();
      push = 1'b1; tick();
      stack_check("two_pushed", 4'h9, 2, 1'b0);
      push = 1'b1; pop = 1'b1; wr_flags = 1'b1; wr_data = 4'h7;
      tick();
      stack_check("push_pop", 4'h7, 2, 1'b0);
      pop = 1'b1; tick();
      stack_check("after_pp_pop", 4'h9, 1, 1'b0);
      push = 1'b1; tick();
      stack_check("pre_reset", 4'h9, 2, 1'b0);

      // Asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      stack_check("async_reset", 4'h0, 0, 1'b0);
      cond_check("async_cond_z", 4'd1, 1'b0);
      #10;
      rst = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
